aes256_key_sched_ctrl: RTL and testbench
========================================

# aes256_key_sched_ctrl

Controller for the AES-256 key-expansion engine (`AESKeyexpansion_256`). It accepts a 256-bit cipher key over a valid/ready handshake and drives the engine's `start` pulse. It captures the 15 round keys into an internal 15×128 bank and serves random-access round-key reads to the cipher round core. The engine streams round keys 1..14; the controller writes round key 0 itself. Per-entry valid bits let the cipher begin round 0 before expansion completes.

## Interface
- No parameters; widths fixed by AES-256.
- `clk` in 1: sole clock.
- `reset` in 1: asynchronous, active-high; clears all state.
- `key_valid` in 1: a cipher key is offered on `key_in`.
- `key_ready` out 1: key accepted on any edge with `key_valid & key_ready`.
- `key_in` in 256: cipher key; bits [255:128] are round key 0.
- `zeroize` in 1: clear the bank and abort any expansion.
- `eng_start` out 1: registered one-cycle start pulse to the engine.
- `eng_key` out 256: latched key, held stable until the next acceptance.
- `eng_subkey` in 128: engine round-key output.
- `eng_cnt` in 4: engine round index.
- `eng_valid` in 1: engine busy/valid.
- `rk_req` in 1: round-key read request.
- `rk_idx` in 4: requested round index, 0..14.
- `rk_valid` out 1: read response, one cycle after `rk_req`.
- `rk_err` out 1: read rejected (index >14 or entry not valid), one cycle after `rk_req`.
- `rk_data` out 128: read data; 0 when `rk_valid`=0.
- `keys_ready` out 1: all 15 entries are valid.
- `busy` out 1: state is START, EXPAND or DRAIN.

## Operation
- States: IDLE, START, EXPAND, READY, DRAIN.
- `key_ready` = (state==IDLE | state==READY) & ~zeroize.
- **Acceptance** (IDLE or READY):
  - latch `eng_key` <= `key_in`.
  - bank[0] <= `key_in[255:128]`.
  - valid bits <= 15'b1 (all others cleared, so a rekey from READY invalidates the old schedule).
  - `eng_start` <= 1; state <= START.
- **START**, one cycle: `eng_start` <= 0; state <= EXPAND.
- **EXPAND**:
  - On every edge with `eng_valid` and 1 <= `eng_cnt` <= 14: bank[eng_cnt] <= `eng_subkey`; set valid[eng_cnt].
  - When `eng_cnt`==14 is captured, state <= READY.
- **READY**: hold the bank; accept a new key.
- **zeroize**, checked in any state, highest priority:
  - clear the bank, valid bits and `eng_key`; `eng_start` <= 0.
  - If state is START or EXPAND, go to DRAIN; otherwise go to IDLE.
- **DRAIN**:
  - Ignore all engine outputs.
  - Leave for IDLE on the first edge with `eng_valid`==0 and `eng_start`==0.
- **Reads**, processed in every state:
  - On the edge with `rk_req`: if `rk_idx`<=14 and valid[rk_idx] (pre-edge value), set `rk_valid`<=1 and `rk_data`<=bank[rk_idx]; else set `rk_err`<=1.
  - Both flags are single-cycle pulses.
  - A read of an entry captured on the same edge returns `rk_err`.
- `keys_ready` = &valid; `busy` is decoded from state.

## Timing
- **Reset values:**
  - state IDLE.
  - `key_ready`=1 (when `zeroize`=0).
  - `eng_start`=0, `eng_key`=0, `rk_valid`=0, `rk_err`=0, `rk_data`=0.
  - `keys_ready`=0, `busy`=0; bank and valid bits 0.
- **Acceptance edge E0:** `eng_start` is high E0..E1.
  - The engine samples start at E1.
  - `eng_cnt`=k is present between E(k) and E(k+1); bank[k] is written at E(k+1), k=1..14.
  - `keys_ready` rises after E15: 15 cycles of latency.
- **Read latency:** 1 cycle; back-to-back reads are allowed every cycle.
- **`zeroize` with `key_valid` on the same edge:** zeroize wins; the key is not accepted.
- **`reset` mid-EXPAND:** everything clears immediately. The engine shares `reset` and also returns to i=0, so no DRAIN is needed.

## Test plan
- **Full expansion.** Stimulus: load key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4; read idx 0..14.
  - `keys_ready` at E15.
  - rk0=603deb1015ca71be2b73aef0857d7781.
  - rk1=1f352c073b6108d72d9810a30914dff4.
  - rk2=9ba354118e6925afa51a8b5f2067fcde.
  - rk14=fe4890d1e6188d0b046df344706c631e.
- **Early read.** Read idx 0 at E1 → `rk_valid` with rk0. Read idx 5 at E3 → `rk_err`. Read idx 5 at E7 → `rk_valid`.
- **Bad index and idle reads.** `rk_idx`=15 after READY → `rk_err`. Any read in IDLE → `rk_err`.
- **Handshake stall.** `key_valid` held during EXPAND → `key_ready`=0 and `eng_key` unchanged. The key is accepted on the first edge in READY; valid bits become 15'b1 and `keys_ready` drops.
- **Zeroize mid-expansion.** Pulse `zeroize` at E6:
  - bank cleared; state goes to DRAIN.
  - `key_ready`=0 until `eng_valid` falls.
  - A second key then expands correctly, and none of its entries contain first-key data.
- **Asynchronous reset at E8.** All outputs reach their reset values before the next edge; a subsequent load completes normally.

Source files
------------

// File: rtl/aes256_key_sched_ctrl.sv
// aes256_key_sched_ctrl
// Sequences the AES-256 key-expansion engine and stores its round keys in a
// 15 x 128 bank. The cipher core reads the bank with one-cycle latency.
//
// Ports:
//   i_clk, i_reset        clock, asynchronous active-high reset
//   i_key_valid/o_key_ready/i_key_in   256-bit cipher key handshake
//   i_zeroize             wipe the bank and abandon any expansion
//   o_eng_start/o_eng_key start pulse and held key to the engine
//   i_eng_subkey/i_eng_cnt/i_eng_valid round-key stream from the engine
//   i_rk_req/i_rk_idx     round-key read request
//   o_rk_valid/o_rk_err/o_rk_data      read response, one cycle later
//   o_keys_ready          all 15 entries hold valid round keys
//   o_busy                an expansion is running or being drained
module aes256_key_sched_ctrl (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_key_valid,
  output logic         o_key_ready,
  input  logic [255:0] i_key_in,
  input  logic         i_zeroize,
  output logic         o_eng_start,
  output logic [255:0] o_eng_key,
  input  logic [127:0] i_eng_subkey,
  input  logic [3:0]   i_eng_cnt,
  input  logic         i_eng_valid,
  input  logic         i_rk_req,
  input  logic [3:0]   i_rk_idx,
  output logic         o_rk_valid,
  output logic         o_rk_err,
  output logic [127:0] o_rk_data,
  output logic         o_keys_ready,
  output logic         o_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_EXPAND,
    S_READY,
    S_DRAIN
  } state_t;

  state_t         r_state;
  state_t         w_next_state;
  logic [127:0]   r_bank [15];
  logic [14:0]    r_valid;
  logic           r_eng_start;
  logic [255:0]   r_eng_key;
  logic           r_rk_valid;
  logic           r_rk_err;
  logic [127:0]   r_rk_data;

  logic           w_key_ready;
  logic           w_accept;
  logic           w_capture;
  logic           w_rd_hit;
  logic [15:0]    w_valid_ext;

  // Handshake, engine-capture and read-hit decode. A read looks at the valid
  // bits before this edge, so an entry written on the same edge still errors.
  // The valid vector is widened so index 15 lands on a constant zero.
  always_comb begin
    w_key_ready = ((r_state == S_IDLE) || (r_state == S_READY)) && !i_zeroize;
    w_accept    = i_key_valid && w_key_ready;
    w_capture   = (r_state == S_EXPAND) && i_eng_valid &&
                  (i_eng_cnt != 4'd0) && (i_eng_cnt <= 4'd14);
    w_valid_ext = {1'b0, r_valid};
    w_rd_hit    = i_rk_req && (i_rk_idx <= 4'd14) && w_valid_ext[i_rk_idx];
  end

  // Next-state logic. Zeroize overrides everything; if the engine is already
  // running it must be allowed to finish in DRAIN before a new start.
  always_comb begin
    w_next_state = r_state;
    if (i_zeroize) begin
      if ((r_state == S_START) || (r_state == S_EXPAND))
        w_next_state = S_DRAIN;
      else
        w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_READY: if (w_accept) w_next_state = S_START;
        S_START:         w_next_state = S_EXPAND;
        S_EXPAND:        if (w_capture && (i_eng_cnt == 4'd14)) w_next_state = S_READY;
        S_DRAIN:         if (!i_eng_valid && !r_eng_start) w_next_state = S_IDLE;
        default:         w_next_state = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // Bank, valid bits, engine key/start and read response. Reads are served
  // in every state; zeroize clears the stored schedule and the latched key.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < 15; i++) r_bank[i] <= '0;
      r_valid     <= '0;
      r_eng_start <= 1'b0;
      r_eng_key   <= '0;
      r_rk_valid  <= 1'b0;
      r_rk_err    <= 1'b0;
      r_rk_data   <= '0;
    end else begin
      r_rk_valid <= w_rd_hit;
      r_rk_err   <= i_rk_req && !w_rd_hit;
      r_rk_data  <= w_rd_hit ? r_bank[i_rk_idx] : '0;
      if (i_zeroize) begin
        for (int i = 0; i < 15; i++) r_bank[i] <= '0;
        r_valid     <= '0;
        r_eng_start <= 1'b0;
        r_eng_key   <= '0;
      end else begin
        r_eng_start <= w_accept;
        if (w_accept) begin
          r_eng_key <= i_key_in;
          r_bank[0] <= i_key_in[255:128];
          r_valid   <= 15'b1;
        end else if (w_capture) begin
          r_bank[i_eng_cnt]  <= i_eng_subkey;
          r_valid[i_eng_cnt] <= 1'b1;
        end
      end
    end
  end

  assign o_key_ready  = w_key_ready;
  assign o_eng_start  = r_eng_start;
  assign o_eng_key    = r_eng_key;
  assign o_rk_valid   = r_rk_valid;
  assign o_rk_err     = r_rk_err;
  assign o_rk_data    = r_rk_data;
  assign o_keys_ready = &r_valid;
  assign o_busy       = (r_state == S_START) || (r_state == S_EXPAND) || (r_state == S_DRAIN);

endmodule

// File: tb/tb_aes256_key_sched_ctrl.sv
// tb_aes256_key_sched_ctrl
// Bench for aes256_key_sched_ctrl. Contains a behavioural AES-256 key
// expansion engine that answers the controller's start pulse, a timeline
// model of the controller checked on every falling edge, and directed tests.
module tb_aes256_key_sched_ctrl;

  typedef logic [14:0][127:0] sched_t;

  logic         i_clk = 1'b0;
  logic         i_reset;
  logic         i_key_valid;
  logic         o_key_ready;
  logic [255:0] i_key_in;
  logic         i_zeroize;
  logic         o_eng_start;
  logic [255:0] o_eng_key;
  logic [127:0] i_eng_subkey;
  logic [3:0]   i_eng_cnt;
  logic         i_eng_valid;
  logic         i_rk_req;
  logic [3:0]   i_rk_idx;
  logic         o_rk_valid;
  logic         o_rk_err;
  logic [127:0] o_rk_data;
  logic         o_keys_ready;
  logic         o_busy;

  localparam logic [255:0] K1 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] K2 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] K3 = 256'hdeadbeefcafef00d0123456789abcdeffedcba98765432100f1e2d3c4b5a6978;
  localparam logic [127:0] RK0  = 128'h603deb1015ca71be2b73aef0857d7781;
  localparam logic [127:0] RK1  = 128'h1f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] RK2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
  localparam logic [127:0] RK14 = 128'hfe4890d1e6188d0b046df344706c631e;

  int nCompared = 0;
  int nMismatch = 0;

  sched_t schedK1;
  sched_t schedK2;

  aes256_key_sched_ctrl dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_key_valid  (i_key_valid),
    .o_key_ready  (o_key_ready),
    .i_key_in     (i_key_in),
    .i_zeroize    (i_zeroize),
    .o_eng_start  (o_eng_start),
    .o_eng_key    (o_eng_key),
    .i_eng_subkey (i_eng_subkey),
    .i_eng_cnt    (i_eng_cnt),
    .i_eng_valid  (i_eng_valid),
    .i_rk_req     (i_rk_req),
    .i_rk_idx     (i_rk_idx),
    .o_rk_valid   (o_rk_valid),
    .o_rk_err     (o_rk_err),
    .o_rk_data    (o_rk_data),
    .o_keys_ready (o_keys_ready),
    .o_busy       (o_busy)
  );

  // Free-running 10-unit clock.
  always #5 i_clk = ~i_clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int n = 0; n < 8; n++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = 8'h01;
    if (a == 8'h00) b = 8'h00;
    else for (int n = 0; n < 254; n++) b = gmul(b, a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic sched_t expandKey(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon;
    sched_t      s;
    rcon = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t = subWord({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = {rcon[6:0], 1'b0};
      end else if (i % 8 == 4) begin
        t = subWord(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) s[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkDiffers(input string name, input logic [127:0] act, input logic [127:0] forbidden);
    nCompared++;
    if (act === forbidden) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %h which must differ from %h", name, act, forbidden);
    end
  endtask

  task automatic applyStimulus(input logic kv, input logic [255:0] key, input logic zer,
                               input logic req, input logic [3:0] idx);
    i_key_valid = kv;
    i_key_in    = key;
    i_zeroize   = zer;
    i_rk_req    = req;
    i_rk_idx    = idx;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // Engine stand-in: samples start/key/reset at each rising edge and, one
  // unit later, presents round key k with cnt=k for one cycle, k=1..14.
  sched_t engSched;
  logic   engStartSeen;
  logic   engResetSeen;
  logic [255:0] engKeySeen;
  initial begin
    i_eng_valid  = 1'b0;
    i_eng_cnt    = 4'd0;
    i_eng_subkey = '0;
    engSched     = '0;
    forever begin
      @(posedge i_clk);
      engStartSeen = o_eng_start;
      engKeySeen   = o_eng_key;
      engResetSeen = i_reset;
      #1;
      if (engResetSeen) begin
        i_eng_valid  = 1'b0;
        i_eng_cnt    = 4'd0;
        i_eng_subkey = '0;
      end else if (engStartSeen) begin
        engSched     = expandKey(engKeySeen);
        i_eng_valid  = 1'b1;
        i_eng_cnt    = 4'd1;
        i_eng_subkey = engSched[1];
      end else if (i_eng_valid) begin
        if (i_eng_cnt == 4'd14) begin
          i_eng_valid  = 1'b0;
          i_eng_cnt    = 4'd0;
          i_eng_subkey = '0;
        end else begin
          i_eng_cnt    = i_eng_cnt + 4'd1;
          i_eng_subkey = engSched[i_eng_cnt];
        end
      end
    end
  end

  // Controller model expressed as a timeline: entry k of the schedule
  // accepted at edge acc becomes readable from edge acc+k+2, the expansion
  // occupies edges acc+1..acc+15, and zeroize during that window leaves the
  // block draining until the engine goes quiet.
  int           cyc = 0;
  int           acc = 0;
  bit           haveKey = 1'b0;
  bit           draining = 1'b0;
  bit           mExpanding;
  bit           mHit;
  logic [255:0] mKey = '0;
  sched_t       mSched = '0;
  logic         eStart = 1'b0;
  logic         eRkValid = 1'b0;
  logic         eRkErr = 1'b0;
  logic [127:0] eRkData = '0;
  logic         eBusy;

  task automatic modelEdge();
    cyc++;
    if (i_reset) begin
      haveKey  = 1'b0;
      draining = 1'b0;
      mKey     = '0;
      eStart   = 1'b0;
      eRkValid = 1'b0;
      eRkErr   = 1'b0;
      eRkData  = '0;
    end else begin
      mExpanding = haveKey && (cyc - acc >= 1) && (cyc - acc <= 15);
      mHit = i_rk_req && (i_rk_idx <= 4'd14) && haveKey &&
             ((i_rk_idx == 4'd0) || (cyc - acc >= int'(i_rk_idx) + 2));
      eRkValid = mHit;
      eRkErr   = i_rk_req && !mHit;
      eRkData  = mHit ? mSched[i_rk_idx] : '0;
      if (i_zeroize) begin
        draining = mExpanding;
        haveKey  = 1'b0;
        mKey     = '0;
        eStart   = 1'b0;
      end else if (draining) begin
        if (!i_eng_valid && !eStart) draining = 1'b0;
        eStart = 1'b0;
      end else if (!mExpanding && i_key_valid) begin
        haveKey = 1'b1;
        acc     = cyc;
        mKey    = i_key_in;
        mSched  = expandKey(i_key_in);
        eStart  = 1'b1;
      end else begin
        eStart = 1'b0;
      end
    end
  endtask

  // Compare process: advance the model on each rising edge, compare every
  // output against it on the following falling edge.
  initial begin
    forever begin
      @(posedge i_clk);
      modelEdge();
      @(negedge i_clk);
      eBusy = (haveKey && (cyc - acc >= 0) && (cyc - acc <= 14)) || draining;
      checkOutput("cmp_busy", o_busy, eBusy);
      checkOutput("cmp_key_ready", o_key_ready, !eBusy && !i_zeroize);
      checkOutput("cmp_keys_ready", o_keys_ready, haveKey && (cyc - acc >= 15));
      checkOutput("cmp_eng_start", o_eng_start, eStart);
      checkOutput("cmp_eng_key", o_eng_key, mKey);
      checkOutput("cmp_rk_valid", o_rk_valid, eRkValid);
      checkOutput("cmp_rk_err", o_rk_err, eRkErr);
      checkOutput("cmp_rk_data", o_rk_data, eRkData);
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed tests.
  initial begin
    int waitCnt;
    schedK1 = expandKey(K1);
    schedK2 = expandKey(K2);
    checkOutput("pin_rk0", schedK1[0], RK0);
    checkOutput("pin_rk1", schedK1[1], RK1);
    checkOutput("pin_rk2", schedK1[2], RK2);
    checkOutput("pin_rk14", schedK1[14], RK14);

    i_reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 4'd0);
    step(2);
    i_reset = 1'b0;
    checkOutput("rst_key_ready", o_key_ready, 1'b1);
    checkOutput("rst_busy", o_busy, 1'b0);
    checkOutput("rst_keys_ready", o_keys_ready, 1'b0);
    checkOutput("rst_eng_start", o_eng_start, 1'b0);
    checkOutput("rst_eng_key", o_eng_key, '0);

    $display("[TB] idle read");
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 4'd3);
    step(1);
    checkOutput("idle_rk_err", o_rk_err, 1'b1);
    checkOutput("idle_rk_valid", o_rk_valid, 1'b0);

    $display("[TB] full expansion with early reads");
    applyStimulus(1'b1, K1, 1'b0, 1'b0, 4'd0);
    step(1);
    checkOutput("e0_eng_start", o_eng_start, 1'b1);
    checkOutput("e0_key_ready", o_key_ready, 1'b0);
    applyStimulus(1'b0, K1, 1'b0, 1'b1, 4'd0);
    step(1);
    checkOutput("e1_rk_valid", o_rk_valid, 1'b1);
    checkOutput("e1_rk_data", o_rk_data, RK0);
    checkOutput("e1_eng_start", o_eng_start, 1'b0);
    applyStimulus(1'b0, K1, 1'b0, 1'b0, 4'd0);
    step(1);
    applyStimulus(1'b0, K1, 1'b0, 1'b1, 4'd5);
    step(1);
    checkOutput("e3_rk_err", o_rk_err, 1'b1);
    checkOutput("e3_rk_valid", o_rk_valid, 1'b0);
    applyStimulus(1'b0, K1, 1'b0, 1'b0, 4'd0);
    step(3);
    applyStimulus(1'b0, K1, 1'b0, 1'b1, 4'd5);
    step(1);
    checkOutput("e7_rk_valid", o_rk_valid, 1'b1);
    checkOutput("e7_rk_data", o_rk_data, schedK1[5]);
    applyStimulus(1'b0, K1, 1'b0, 1'b0, 4'd0);
    step(7);
    checkOutput("e14_keys_ready", o_keys_ready, 1'b0);
    step(1);
    checkOutput("e15_keys_ready", o_keys_ready, 1'b1);
    checkOutput("e15_busy", o_busy, 1'b0);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b0, K1, 1'b0, 1'b1, 4'(i));
      step(1);
      checkOutput($sformatf("rd_valid_%0d", i), o_rk_valid, 1'b1);
      if (i == 0)  checkOutput("rd_rk0", o_rk_data, RK0);
      if (i == 1)  checkOutput("rd_rk1", o_rk_data, RK1);
      if (i == 2)  checkOutput("rd_rk2", o_rk_data, RK2);
      if (i == 14) checkOutput("rd_rk14", o_rk_data, RK14);
    end
    applyStimulus(1'b0, K1, 1'b0, 1'b1, 4'd15);
    step(1);
    checkOutput("idx15_rk_err", o_rk_err, 1'b1);
    checkOutput("idx15_rk_data", o_rk_data, '0);

    $display("[TB] handshake stall");
    applyStimulus(1'b1, K2, 1'b0, 1'b0, 4'd0);
    step(1);
    applyStimulus(1'b1, K3, 1'b0, 1'b0, 4'd0);
    step(5);
    checkOutput("stall_key_ready", o_key_ready, 1'b0);
    checkOutput("stall_eng_key", o_eng_key, K2);
    step(10);
    checkOutput("stall_e15_keys_ready", o_keys_ready, 1'b1);
    step(1);
    checkOutput("stall_accept_key", o_eng_key, K3);
    checkOutput("stall_accept_keys_ready", o_keys_ready, 1'b0);
    checkOutput("stall_accept_start", o_eng_start, 1'b1);
    applyStimulus(1'b0, K3, 1'b0, 1'b0, 4'd0);
    step(15);
    checkOutput("k3_keys_ready", o_keys_ready, 1'b1);
    applyStimulus(1'b0, K3, 1'b0, 1'b1, 4'd14);
    step(1);
    checkOutput("k3_rd14_valid", o_rk_valid, 1'b1);

    $display("[TB] zeroize");
    applyStimulus(1'b1, K1, 1'b1, 1'b0, 4'd0);
    step(1);
    checkOutput("zkv_eng_start", o_eng_start, 1'b0);
    checkOutput("zkv_busy", o_busy, 1'b0);
    checkOutput("zkv_keys_ready", o_keys_ready, 1'b0);
    checkOutput("zkv_eng_key", o_eng_key, '0);
    applyStimulus(1'b1, K1, 1'b0, 1'b0, 4'd0);
    step(1);
    applyStimulus(1'b0, K1, 1'b0, 1'b0, 4'd0);
    step(5);
    applyStimulus(1'b0, K1, 1'b1, 1'b0, 4'd0);
    step(1);
    checkOutput("z6_busy", o_busy, 1'b1);
    checkOutput("z6_eng_key", o_eng_key, '0);
    applyStimulus(1'b0, K1, 1'b0, 1'b1, 4'd0);
    step(1);
    checkOutput("z7_rk_err", o_rk_err, 1'b1);
    checkOutput("z7_key_ready", o_key_ready, 1'b0);
    applyStimulus(1'b0, K1, 1'b0, 1'b0, 4'd0);
    waitCnt = 0;
    while (!o_key_ready && waitCnt < 40) begin
      step(1);
      waitCnt++;
    end
    checkOutput("drain_exit", o_key_ready, 1'b1);
    applyStimulus(1'b1, K2, 1'b0, 1'b0, 4'd0);
    step(1);
    applyStimulus(1'b0, K2, 1'b0, 1'b0, 4'd0);
    step(15);
    checkOutput("k2_keys_ready", o_keys_ready, 1'b1);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b0, K2, 1'b0, 1'b1, 4'(i));
      step(1);
      checkOutput($sformatf("k2_rd_%0d", i), o_rk_data, schedK2[i]);
      checkDiffers($sformatf("k2_not_k1_%0d", i), o_rk_data, schedK1[i]);
    end

    $display("[TB] asynchronous reset during expansion");
    applyStimulus(1'b1, K1, 1'b0, 1'b0, 4'd0);
    step(1);
    applyStimulus(1'b0, K1, 1'b0, 1'b0, 4'd0);
    step(7);
    #5;
    i_reset = 1'b1;
    #1;
    checkOutput("arst_key_ready", o_key_ready, 1'b1);
    checkOutput("arst_busy", o_busy, 1'b0);
    checkOutput("arst_keys_ready", o_keys_ready, 1'b0);
    checkOutput("arst_eng_start", o_eng_start, 1'b0);
    checkOutput("arst_eng_key", o_eng_key, '0);
    checkOutput("arst_rk_valid", o_rk_valid, 1'b0);
    checkOutput("arst_rk_err", o_rk_err, 1'b0);
    checkOutput("arst_rk_data", o_rk_data, '0);
    step(1);
    i_reset = 1'b0;
    applyStimulus(1'b1, K1, 1'b0, 1'b0, 4'd0);
    step(1);
    applyStimulus(1'b0, K1, 1'b0, 1'b0, 4'd0);
    step(15);
    checkOutput("reload_keys_ready", o_keys_ready, 1'b1);
    applyStimulus(1'b0, K1, 1'b0, 1'b1, 4'd14);
    step(1);
    checkOutput("reload_rk14", o_rk_data, RK14);
    applyStimulus(1'b0, K1, 1'b0, 1'b0, 4'd0);
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
